// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch stage, its instruction ROM and the control unit.
// The master modport is the fetch stage side; slave is the ROM/uc/datapath side.
interface fetch_unit_if #(
    parameter int unsigned PC_W    = 10,
    parameter int unsigned INSTR_W = 16
);
    logic               s_inc;
    logic               stall;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr;
    logic [5:0]         opcode;
    logic [PC_W-1:0]    pc;
    logic               instr_valid;

    modport master (
        input  s_inc,
        input  stall,
        input  imem_rdata,
        output imem_addr,
        output instr,
        output opcode,
        output pc,
        output instr_valid
    );

    modport slave (
        output s_inc,
        output stall,
        output imem_rdata,
        input  imem_addr,
        input  instr,
        input  opcode,
        input  pc,
        input  instr_valid
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a synchronous-read ROM and presents the
// fetched instruction with a valid flag; a taken jump costs one squashed cycle.
module fetch_unit #(
    parameter int unsigned     PC_W     = 10,
    parameter int unsigned     INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    localparam logic [PC_W-1:0] PcOne = PC_W'(1);

    typedef enum logic [1:0] {StBoot, StRun, StBubble} state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;  // address currently presented to the ROM
    logic [PC_W-1:0]    instr_pc_q, instr_pc_d;  // address of the presented instruction
    logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
    logic               hold_valid_q, hold_valid_d;
    logic [INSTR_W-1:0] instr;

    // While stalled the ROM has already moved on to the next word, so the held copy is used.
    assign instr = hold_valid_q ? hold_instr_q : bus.imem_rdata;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        instr_pc_d   = instr_pc_q;
        hold_instr_d = hold_instr_q;
        hold_valid_d = hold_valid_q;

        unique case (state_q)
            StBoot, StBubble: begin
                instr_pc_d   = fetch_pc_q;
                fetch_pc_d   = fetch_pc_q + PcOne;
                hold_valid_d = 1'b0;
                state_d      = StRun;
            end
            StRun: begin
                if (bus.stall) begin
                    if (!hold_valid_q) begin
                        hold_instr_d = bus.imem_rdata;
                        hold_valid_d = 1'b1;
                    end
                end else begin
                    hold_valid_d = 1'b0;
                    if (bus.s_inc) begin
                        instr_pc_d = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + PcOne;
                    end else begin
                        fetch_pc_d = instr[PC_W-1:0];
                        state_d    = StBubble;
                    end
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StBoot;
            fetch_pc_q   <= RESET_PC;
            instr_pc_q   <= RESET_PC;
            hold_instr_q <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            instr_pc_q   <= instr_pc_d;
            hold_instr_q <= hold_instr_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr       = instr;
    assign bus.opcode      = instr[INSTR_W-1 -: 6];
    assign bus.pc          = instr_pc_q;
    assign bus.instr_valid = (state_q == StRun);
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random s_inc/stall/reset traffic, checked
// against a cycle-level model of which instruction the stage should be presenting.
module tb_fetch_unit;
    localparam int unsigned   PW     = 10;
    localparam int unsigned   IW     = 16;
    localparam logic [PW-1:0] RST_PC = '0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_unit_if #(.PC_W(PW), .INSTR_W(IW)) bus ();
    fetch_unit_if #(.PC_W(4),  .INSTR_W(IW)) bus4 ();

    fetch_unit #(.PC_W(PW), .INSTR_W(IW), .RESET_PC(RST_PC)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    fetch_unit #(.PC_W(4), .INSTR_W(IW), .RESET_PC(4'h0)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.master)
    );

    logic [IW-1:0] mem  [1024];
    logic [IW-1:0] mem4 [16];

    always @(posedge clk) bus.imem_rdata  <= mem[bus.imem_addr];
    always @(posedge clk) bus4.imem_rdata <= mem4[bus4.imem_addr];

    int n_tests = 0;
    int n_fail  = 0;

    // Model: either presenting a valid instruction at m_pc, or in one dead cycle after
    // which the instruction at m_next appears.
    logic          m_valid;
    logic          m_rst;
    logic [PW-1:0] m_pc;
    logic [PW-1:0] m_next;
    logic          m4_valid;
    logic [3:0]    m4_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_update(input logic rst, input logic inc, input logic stl);
        if (rst) begin
            m_rst    = 1'b1;
            m_valid  = 1'b0;
            m_pc     = RST_PC;
            m_next   = RST_PC;
            m4_valid = 1'b0;
            m4_pc    = 4'h0;
        end else begin
            m_rst = 1'b0;
            if (!m_valid) begin
                m_valid = 1'b1;
                m_pc    = m_next;
            end else if (!stl) begin
                if (inc) begin
                    m_pc = m_pc + 1'b1;
                end else begin
                    m_valid = 1'b0;
                    m_next  = mem[m_pc][PW-1:0];
                end
            end
            if (!m4_valid) m4_valid = 1'b1;
            else           m4_pc    = m4_pc + 1'b1;
        end
    endtask

    task automatic check_outputs();
        logic [IW-1:0] w;
        check("valid", 32'(bus.instr_valid), 32'(m_valid));
        if (m_rst) begin
            check("imem_addr_rst", 32'(bus.imem_addr), 32'(RST_PC));
            check("pc_rst", 32'(bus.pc), 32'(RST_PC));
        end
        if (m_valid) begin
            w = mem[m_pc];
            check("pc", 32'(bus.pc), 32'(m_pc));
            check("instr", 32'(bus.instr), 32'(w));
            check("opcode", 32'(bus.opcode), 32'(w[IW-1 -: 6]));
        end
        check("valid4", 32'(bus4.instr_valid), 32'(m4_valid));
        if (m4_valid) begin
            check("pc4", 32'(bus4.pc), 32'(m4_pc));
            check("instr4", 32'(bus4.instr), 32'(mem4[m4_pc]));
        end
    endtask

    task automatic step(input logic rst, input logic inc, input logic stl);
        reset     = rst;
        bus.s_inc = inc;
        bus.stall = stl;
        @(posedge clk);
        model_update(rst, inc, stl);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        reset      = 1'b1;
        bus.s_inc  = 1'b0;
        bus.stall  = 1'b0;
        bus4.s_inc = 1'b1;
        bus4.stall = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = IW'(i);
        for (int i = 0; i < 16; i++) mem4[i] = 16'hA500 + IW'(i);

        // Reset, boot, sequential run, stall at pc=5, then jump-to-self at pc=6.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);

        // Jump 3 -> 0x020, then 0x021 -> 0x3FE and wrap through 0x3FF to 0.
        mem[3]      = 16'h0020;
        mem[12'h21] = 16'hABFE;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);

        // Reset during a bubble (pc=1 jumps to itself), then reset during a stall at pc=1.
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);

        // Random program and random control traffic.
        for (int i = 0; i < 1024; i++) mem[i] = IW'($urandom);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
